// File: rtl/mix_sequencer.sv
// mix_sequencer: per-sample voice mixing sequencer with filter/bypass routing.
// Optional clamp-on-narrowing enabled by defining MIX_SEQ_SAT_EN.
module mix_sequencer #(
   parameter int NUM_VOICES = 3,
   parameter int WAVE_W     = 10,
   parameter int ENV_W      = 8,
   parameter int ACC_W      = 14,
   parameter int VOL_W      = 8,
   parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     sample_tick_i,
   input  logic [NUM_VOICES-1:0]    route_i,
   input  logic [VOL_W-1:0]         vol_i,
   output logic                     voice_start_o,
   output logic [IDX_W-1:0]         voice_idx_o,
   input  logic                     voice_ready_i,
   input  logic signed [WAVE_W-1:0] wave_i,
   input  logic [ENV_W-1:0]         env_i,
   output logic                     mult_start_o,
   output logic signed [23:0]       mult_a_o,
   output logic signed [15:0]       mult_b_o,
   input  logic                     mult_ready_i,
   input  logic signed [39:0]       mult_prod_i,
   output logic                     filt_start_o,
   input  logic                     filt_ready_i,
   input  logic signed [ACC_W-1:0]  filt_i,
   output logic signed [ACC_W-1:0]  filter_bus_o,
   output logic signed [ACC_W-1:0]  bypass_bus_o,
   output logic signed [ACC_W-1:0]  audio_o,
   output logic                     audio_valid_o,
   output logic                     overrun_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_VREQ, S_VWAIT, S_MUL, S_MWAIT,
      S_FREQ, S_FWAIT, S_VOL, S_VOLWAIT, S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

`ifdef MIX_SEQ_SAT_EN
   localparam logic signed [40:0] MAXV = (41'sd1 <<< (ACC_W - 1)) - 41'sd1;
   localparam logic signed [40:0] MINV = -(41'sd1 <<< (ACC_W - 1));
`endif

   // Narrow a wide signed value to the bus width (clamp or wrap).
   function automatic logic signed [ACC_W-1:0] f_narrow(
      input logic signed [40:0] x
   );
`ifdef MIX_SEQ_SAT_EN
      if (x > MAXV) return ACC_W'(MAXV);
      if (x < MINV) return ACC_W'(MINV);
      return x[ACC_W-1:0];
`else
      return x[ACC_W-1:0];
`endif
   endfunction

   function automatic logic signed [40:0] f_sx(
      input logic signed [ACC_W-1:0] v
   );
      return 41'(v);
   endfunction

   state_t                    r_state;
   logic [IDX_W-1:0]          r_cnt;
   logic [NUM_VOICES-1:0]     r_route;
   logic                      r_voice_start;
   logic [IDX_W-1:0]          r_voice_idx;
   logic                      r_mult_start;
   logic signed [23:0]        r_mult_a;
   logic signed [15:0]        r_mult_b;
   logic                      r_filt_start;
   logic signed [ACC_W-1:0]   r_fbus;
   logic signed [ACC_W-1:0]   r_bbus;
   logic signed [ACC_W-1:0]   r_audio;
   logic                      r_audio_valid;

   logic signed [40:0]        w_prod_ext;
   logic signed [ACC_W-1:0]   w_term;
   logic signed [ACC_W-1:0]   w_fsum;
   logic signed [ACC_W-1:0]   w_bsum;
   logic signed [ACC_W-1:0]   w_mix;

   assign w_prod_ext = 41'(mult_prod_i);
   assign w_term     = f_narrow(w_prod_ext >>> 8);
   assign w_fsum     = f_narrow(f_sx(r_fbus) + f_sx(w_term));
   assign w_bsum     = f_narrow(f_sx(r_bbus) + f_sx(w_term));
   assign w_mix      = f_narrow(f_sx(filt_i) + f_sx(r_bbus));

   // Frame sequencer: voice loop, filter pass, volume pass, audio strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_route       <= '0;
         r_voice_start <= 1'b0;
         r_voice_idx   <= '0;
         r_mult_start  <= 1'b0;
         r_mult_a      <= '0;
         r_mult_b      <= '0;
         r_filt_start  <= 1'b0;
         r_fbus        <= '0;
         r_bbus        <= '0;
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
      end else begin
         r_voice_start <= 1'b0;
         r_mult_start  <= 1'b0;
         r_filt_start  <= 1'b0;
         r_audio_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (sample_tick_i) begin
                  r_fbus        <= '0;
                  r_bbus        <= '0;
                  r_cnt         <= '0;
                  r_route       <= route_i;
                  r_voice_idx   <= '0;
                  r_voice_start <= 1'b1;
                  r_state       <= S_VREQ;
               end
            end
            S_VREQ: r_state <= S_VWAIT;
            S_VWAIT: begin
               if (voice_ready_i) begin
                  r_mult_a     <= 24'(wave_i);
                  r_mult_b     <= 16'(env_i);
                  r_mult_start <= 1'b1;
                  r_state      <= S_MUL;
               end
            end
            S_MUL: r_state <= S_MWAIT;
            S_MWAIT: begin
               if (mult_ready_i) begin
                  r_mult_a <= '0;
                  r_mult_b <= '0;
                  if (r_route[r_cnt]) r_fbus <= w_fsum;
                  else                r_bbus <= w_bsum;
                  if (r_cnt == LAST) begin
                     r_filt_start <= 1'b1;
                     r_state      <= S_FREQ;
                  end else begin
                     r_cnt         <= r_cnt + IDX_W'(1);
                     r_voice_idx   <= r_cnt + IDX_W'(1);
                     r_voice_start <= 1'b1;
                     r_state       <= S_VREQ;
                  end
               end
            end
            S_FREQ: r_state <= S_FWAIT;
            S_FWAIT: begin
               if (filt_ready_i) begin
                  r_mult_a     <= 24'(w_mix);
                  r_mult_b     <= 16'(vol_i);
                  r_mult_start <= 1'b1;
                  r_state      <= S_VOL;
               end
            end
            S_VOL: r_state <= S_VOLWAIT;
            S_VOLWAIT: begin
               if (mult_ready_i) begin
                  r_mult_a      <= '0;
                  r_mult_b      <= '0;
                  r_audio       <= w_term;
                  r_audio_valid <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign voice_start_o = r_voice_start;
   assign voice_idx_o   = r_voice_idx;
   assign mult_start_o  = r_mult_start;
   assign mult_a_o      = r_mult_a;
   assign mult_b_o      = r_mult_b;
   assign filt_start_o  = r_filt_start;
   assign filter_bus_o  = r_fbus;
   assign bypass_bus_o  = r_bbus;
   assign audio_o       = r_audio;
   assign audio_valid_o = r_audio_valid;
   // A tick seen while a frame is in flight is dropped and flagged at once.
   assign overrun_o     = sample_tick_i & (r_state != S_IDLE);

endmodule

// File: tb/tb_mix_sequencer.sv
// tb_mix_sequencer: randomized scoreboard bench for mix_sequencer.
// Honours MIX_SEQ_SAT_EN in its reference model.
module tb_mix_sequencer;
   localparam int NV = 3;
   localparam int WW = 10;
   localparam int EW = 8;
   localparam int AW = 14;
   localparam int VW = 8;
   localparam int IW = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  sample_tick_i = 1'b0;
   logic [NV-1:0]         route_i = '0;
   logic [VW-1:0]         vol_i = '0;
   logic                  voice_start_o;
   logic [IW-1:0]         voice_idx_o;
   logic                  voice_ready_i = 1'b0;
   logic signed [WW-1:0]  wave_i = '0;
   logic [EW-1:0]         env_i = '0;
   logic                  mult_start_o;
   logic signed [23:0]    mult_a_o;
   logic signed [15:0]    mult_b_o;
   logic                  mult_ready_i = 1'b0;
   logic signed [39:0]    mult_prod_i = '0;
   logic                  filt_start_o;
   logic                  filt_ready_i = 1'b0;
   logic signed [AW-1:0]  filt_i = '0;
   logic signed [AW-1:0]  filter_bus_o;
   logic signed [AW-1:0]  bypass_bus_o;
   logic signed [AW-1:0]  audio_o;
   logic                  audio_valid_o;
   logic                  overrun_o;

   mix_sequencer #(
      .NUM_VOICES(NV), .WAVE_W(WW), .ENV_W(EW), .ACC_W(AW), .VOL_W(VW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .sample_tick_i(sample_tick_i),
      .route_i(route_i), .vol_i(vol_i),
      .voice_start_o(voice_start_o), .voice_idx_o(voice_idx_o),
      .voice_ready_i(voice_ready_i), .wave_i(wave_i), .env_i(env_i),
      .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
      .mult_ready_i(mult_ready_i), .mult_prod_i(mult_prod_i),
      .filt_start_o(filt_start_o), .filt_ready_i(filt_ready_i),
      .filt_i(filt_i), .filter_bus_o(filter_bus_o),
      .bypass_bus_o(bypass_bus_o), .audio_o(audio_o),
      .audio_valid_o(audio_valid_o), .overrun_o(overrun_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      longint au;
      longint fb;
      longint bb;
      longint due;
   } exp_t;

   exp_t   sb[$];
   int     wv[NV];
   int     ev[NV];
   int     filt_v = 0;
   bit     rnd_lat = 1'b0;
   bit     busy = 1'b0;
   int     vcnt = 0;
   int     passed = 0;
   int     total = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Bus-width narrowing of an ideal integer.
   function automatic longint nar(input longint x);
      longint h = 64'sd1 <<< (AW - 1);
      longint m;
`ifdef MIX_SEQ_SAT_EN
      m = x;
      if (x > h - 1) m = h - 1;
      if (x < -h) m = -h;
`else
      m = x & (2 * h - 1);
      if (m >= h) m = m - 2 * h;
`endif
      return m;
   endfunction

   // Whole-frame result from the voice data, routing, filter value, volume.
   function automatic exp_t model(input logic [NV-1:0] rt, input int fv,
                                  input int vol, input longint due);
      exp_t   e;
      longint term;
      e.fb = 0;
      e.bb = 0;
      for (int i = 0; i < NV; i++) begin
         term = nar((longint'(wv[i]) * longint'(ev[i])) >>> 8);
         if (rt[i]) e.fb = nar(e.fb + term);
         else       e.bb = nar(e.bb + term);
      end
      e.au  = nar((nar(longint'(fv) + e.bb) * longint'(vol)) >>> 8);
      e.due = due;
      return e;
   endfunction

   function automatic int lat();
      return rnd_lat ? int'($urandom_range(0, 2)) : 0;
   endfunction

   // Voice responder.
   initial begin : voice_resp
      int cnt;
      int idx;
      cnt = 0;
      idx = 0;
      forever begin
         @(posedge clk_i); #1;
         voice_ready_i = 1'b0;
         if (rst_i) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  voice_ready_i = 1'b1;
                  wave_i = WW'(wv[idx]);
                  env_i  = EW'(ev[idx]);
               end
            end
            if (voice_start_o) begin
               idx = int'(voice_idx_o);
               cnt = 1 + lat();
            end
         end
      end
   end

   // Multiplier responder.
   initial begin : mult_resp
      int     cnt;
      longint p;
      cnt = 0;
      p = 0;
      forever begin
         @(posedge clk_i); #1;
         mult_ready_i = 1'b0;
         if (rst_i) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  mult_ready_i = 1'b1;
                  mult_prod_i = 40'(p);
               end
            end
            if (mult_start_o) begin
               p = longint'(mult_a_o) * longint'(mult_b_o);
               cnt = 1 + lat();
            end
         end
      end
   end

   // Filter responder.
   initial begin : filt_resp
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk_i); #1;
         filt_ready_i = 1'b0;
         if (rst_i) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  filt_ready_i = 1'b1;
                  filt_i = AW'(filt_v);
               end
            end
            if (filt_start_o) cnt = 1 + lat();
         end
      end
   end

   // Monitor and scoreboard.
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            if (sample_tick_i || overrun_o)
               chk("overrun", overrun_o, sample_tick_i && busy);
            if (sample_tick_i && !busy) begin
               sb.push_back(model(route_i, filt_v, int'(vol_i),
                                  rnd_lat ? -1 : cyc + 5 + 4 * NV));
               busy = 1'b1;
               vcnt = 0;
            end
            if (voice_start_o) begin
               chk("voice_idx", voice_idx_o, vcnt);
               vcnt++;
            end
            if (audio_valid_o) begin
               if (sb.size() == 0) begin
                  total++;
                  $display("FAIL audio_valid: got strobe expected none");
               end else begin
                  e = sb.pop_front();
                  chk("audio", audio_o, e.au);
                  chk("filter_bus", filter_bus_o, e.fb);
                  chk("bypass_bus", bypass_bus_o, e.bb);
                  if (e.due >= 0) chk("valid_cycle", cyc, e.due);
               end
               busy = 1'b0;
            end
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_vstart"}, voice_start_o, 0);
      chk({tag, "_vidx"}, voice_idx_o, 0);
      chk({tag, "_mstart"}, mult_start_o, 0);
      chk({tag, "_ma"}, mult_a_o, 0);
      chk({tag, "_mb"}, mult_b_o, 0);
      chk({tag, "_fstart"}, filt_start_o, 0);
      chk({tag, "_fbus"}, filter_bus_o, 0);
      chk({tag, "_bbus"}, bypass_bus_o, 0);
      chk({tag, "_audio"}, audio_o, 0);
      chk({tag, "_valid"}, audio_valid_o, 0);
      chk({tag, "_ovr"}, overrun_o, 0);
   endtask

   task automatic do_tick(output int t);
      sample_tick_i = 1'b1;
      t = cyc;
      @(posedge clk_i); #1;
      sample_tick_i = 1'b0;
      route_i = NV'($urandom);
   endtask

   task automatic tick_at(input int k);
      while (cyc < k) begin
         @(posedge clk_i); #1;
      end
      sample_tick_i = 1'b1;
      @(posedge clk_i); #1;
      sample_tick_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(posedge clk_i); #1;
         n++;
      end
      if (busy) begin
         total++;
         $display("FAIL timeout: got busy after %0d cycles expected idle", n);
         busy = 1'b0;
         sb.delete();
      end
      repeat (1 + (rnd_lat ? $urandom_range(0, 2) : 0)) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic set_all(input int w, input int e);
      for (int i = 0; i < NV; i++) begin
         wv[i] = w;
         ev[i] = e;
      end
   endtask

   task automatic frame(input logic [NV-1:0] rt);
      int t;
      route_i = rt;
      do_tick(t);
      wait_idle();
   endtask

   initial begin : main
      int t;
      set_all(0, 0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk_zero("reset");
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      set_all(511, 255);
      filt_v = 0;
      vol_i = 8'd255;
      frame(3'b000);
      frame(3'b101);

      set_all(0, 0);
      wv[0] = -512;
      ev[0] = 128;
      frame(3'b000);

      set_all(0, 0);
      wv[0] = 511;
      ev[0] = 255;
      filt_v = 8000;
      frame(3'b000);

      set_all(511, 255);
      filt_v = 0;
      route_i = '0;
      do_tick(t);
      tick_at(t + 3);
      tick_at(t + 17);
      tick_at(t + 18);
      wait_idle();

      route_i = '0;
      do_tick(t);
      while (cyc < t + 8) begin
         @(posedge clk_i); #1;
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      chk_zero("midreset");
      sb.delete();
      busy = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      frame(3'b000);

      rnd_lat = 1'b1;
      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < NV; i++) begin
            wv[i] = int'($urandom_range(0, 1023)) - 512;
            ev[i] = int'($urandom_range(0, 255));
         end
         filt_v = int'($urandom_range(0, 16383)) - 8192;
         vol_i = VW'($urandom);
         frame(NV'($urandom));
      end

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
